// File: rtl/sw_prio_encoder.sv
// Switch input stage: two-flop synchroniser, optional debounce, registered priority encode.
// Debounce FSM is built only when SW_PRIO_ENCODER_DEBOUNCE_EN is defined.
//
// state  | meaning
// STABLE | sw_sync matches the accepted vector; waiting for a change
// SETTLE | counting consecutive samples of the candidate vector in cand

module sw_prio_encoder #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] sw,
  output logic [2:0] encoded,
  output logic       valid,
  output logic       changed
);

  logic [7:0] s1;
  logic [7:0] sw_sync;
  logic [7:0] sw_stable;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1      <= '0;
      sw_sync <= '0;
    end else begin
      s1      <= sw;
      sw_sync <= s1;
    end
  end

`ifdef SW_PRIO_ENCODER_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic {
    STABLE,
    SETTLE
  } state_t;

  state_t           state;
  logic [7:0]       cand;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= STABLE;
      sw_stable <= '0;
      cand      <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        STABLE: begin
          if (sw_sync != sw_stable) begin
            cand  <= sw_sync;
            cnt   <= CNT_W'(1);
            state <= SETTLE;
          end
        end
        SETTLE: begin
          if (sw_sync == sw_stable) begin
            cnt   <= '0;
            state <= STABLE;
          end else if (sw_sync != cand) begin
            cand <= sw_sync;
            cnt  <= CNT_W'(1);
          end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            sw_stable <= cand;
            cnt       <= '0;
            state     <= STABLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= STABLE;
      endcase
    end
  end
`else
  // Without debounce the synchronised vector is accepted as-is.
  logic [15:0] unused_debounce_cycles;
  assign unused_debounce_cycles = 16'(DEBOUNCE_CYCLES);
  assign sw_stable = sw_sync;
`endif

  logic [2:0] enc_next;
  logic       valid_next;

  // Ascending scan so the highest set bit wins.
  always_comb begin
    enc_next   = '0;
    valid_next = 1'b0;
    if (en) begin
      for (int i = 0; i < 8; i++) begin
        if (sw_stable[i]) begin
          enc_next   = 3'(i);
          valid_next = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      encoded <= '0;
      valid   <= 1'b0;
      changed <= 1'b0;
    end else begin
      encoded <= enc_next;
      valid   <= valid_next;
      changed <= ({valid_next, enc_next} != {valid, encoded});
    end
  end

endmodule

// File: tb/tb_sw_prio_encoder.sv
// Self-checking bench for sw_prio_encoder: per-cycle compare against a vector-level model
// plus directed literal checks; adapts to SW_PRIO_ENCODER_DEBOUNCE_EN.

module tb_sw_prio_encoder;

  localparam int D = 4;
`ifdef SW_PRIO_ENCODER_DEBOUNCE_EN
  localparam int LAT = D + 2;
`else
  localparam int LAT = 2;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en  = 1'b1;
  logic [7:0] sw  = 8'h00;
  logic [2:0] encoded;
  logic       valid;
  logic       changed;

  int checks   = 0;
  int failures = 0;

  sw_prio_encoder #(.DEBOUNCE_CYCLES(D)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .sw      (sw),
    .encoded (encoded),
    .valid   (valid),
    .changed (changed)
  );

  always #5 clk = ~clk;

  // Model state: accepted vector is whatever sw_sync showed for D consecutive samples.
  logic [7:0] m_s1 = '0, m_sync = '0, m_stable = '0, m_last = '0;
  int         m_run = 0;
  logic [2:0] m_enc = '0;
  logic       m_valid = 1'b0, m_changed = 1'b0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic chk_out(input string name, input logic [2:0] e, input logic v, input logic c);
    chk({name, "_encoded"}, 8'(encoded), 8'(e));
    chk({name, "_valid"}, 8'(valid), 8'(v));
    chk({name, "_changed"}, 8'(changed), 8'(c));
  endtask

  // Vector applied at a negedge; output must hold off until edge LAT, pulse changed, then settle.
  task automatic expect_update(input string name, input logic [2:0] e, input logic v);
    cycles(LAT);
    chk({name, "_early_changed"}, 8'(changed), 8'h00);
    cycles(1);
    chk_out(name, e, v, 1'b1);
    cycles(1);
    chk({name, "_pulse_end"}, 8'(changed), 8'h00);
  endtask

  task automatic model_thread();
    logic [7:0] src;
    logic [2:0] ne;
    logic       nv;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        m_s1 = '0; m_sync = '0; m_stable = '0; m_last = '0; m_run = 0;
        m_enc = '0; m_valid = 1'b0; m_changed = 1'b0;
      end else begin
`ifdef SW_PRIO_ENCODER_DEBOUNCE_EN
        src = m_stable;
`else
        src = m_sync;
`endif
        nv = en && (src != 0);
        ne = nv ? 3'($clog2(int'(src) + 1) - 1) : 3'd0;
        m_changed = ({nv, ne} != {m_valid, m_enc});
        m_valid = nv;
        m_enc = ne;
        if (m_sync == m_last) m_run = (m_run < 1000) ? m_run + 1 : m_run;
        else m_run = 1;
        m_last = m_sync;
        if (m_sync != m_stable && m_run >= D) m_stable = m_sync;
        m_sync = m_s1;
        m_s1 = sw;
      end
    end
  endtask

  task automatic compare_thread();
    forever begin
      @(negedge clk);
      chk("cyc_encoded", 8'(encoded), 8'(m_enc));
      chk("cyc_valid", 8'(valid), 8'(m_valid));
      chk("cyc_changed", 8'(changed), 8'(m_changed));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog t=%0t got=timeout expected=finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    fork
      model_thread();
      compare_thread();
    join_none

    // Reset held with all switches on
    rst = 1'b0; en = 1'b1; sw = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      cycles(1);
      chk_out("in_reset", 3'd0, 1'b0, 1'b0);
    end
    rst = 1'b1;
    expect_update("reset_release", 3'd7, 1'b1);

    // Priority
    sw = 8'b0010_0110;
    expect_update("prio_26", 3'd5, 1'b1);
    sw = 8'b0000_0001;
    expect_update("prio_01", 3'd0, 1'b1);
    sw = 8'h00;
    expect_update("prio_00", 3'd0, 1'b0);

    // Bounce: 2-cycle toggles never survive debounce
    for (int i = 0; i < 10; i++) begin
      sw = (i % 2 == 0) ? 8'h08 : 8'h00;
      for (int k = 0; k < 2; k++) begin
        cycles(1);
`ifdef SW_PRIO_ENCODER_DEBOUNCE_EN
        chk("bounce_valid", 8'(valid), 8'h00);
        chk("bounce_changed", 8'(changed), 8'h00);
`endif
      end
    end
    sw = 8'h08;
    expect_update("bounce_hold", 3'd3, 1'b1);

    // Enable
    sw = 8'h40;
    expect_update("en_base", 3'd6, 1'b1);
    en = 1'b0;
    cycles(1);
    chk_out("en_drop", 3'd0, 1'b0, 1'b1);
    cycles(1);
    chk("en_drop_settle", 8'(changed), 8'h00);
    en = 1'b1;
    cycles(1);
    chk_out("en_raise", 3'd6, 1'b1, 1'b1);
    cycles(2);

    // en falls on the edge where the new vector commits
    sw = 8'h02;
    cycles(LAT - 1);
    en = 1'b0;
    cycles(1);
    chk_out("simul_commit", 3'd0, 1'b0, 1'b1);
    cycles(2);
    chk_out("simul_hold", 3'd0, 1'b0, 1'b0);
    en = 1'b1;
    cycles(1);
    chk_out("simul_reenable", 3'd1, 1'b1, 1'b1);
    cycles(1);

    // Reset in the middle of settling
    sw = 8'h01;
    expect_update("mid_base", 3'd0, 1'b1);
    sw = 8'h80;
    cycles(3);
    rst = 1'b0;
    #1;
    chk_out("mid_reset_now", 3'd0, 1'b0, 1'b0);
    cycles(1);
    rst = 1'b1;
    expect_update("mid_reset_after", 3'd7, 1'b1);

    // Single-cycle glitch
    sw = 8'h10;
    expect_update("glitch_base", 3'd4, 1'b1);
    sw = 8'h90;
    cycles(1);
    sw = 8'h10;
`ifdef SW_PRIO_ENCODER_DEBOUNCE_EN
    for (int i = 0; i < 8; i++) begin
      cycles(1);
      chk_out("glitch_filtered", 3'd4, 1'b1, 1'b0);
    end
`else
    cycles(2);
    chk_out("glitch_seen", 3'd7, 1'b1, 1'b1);
    cycles(1);
    chk_out("glitch_gone", 3'd4, 1'b1, 1'b1);
    cycles(2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sw_prio_encoder.md
# sw_prio_encoder

Input stage for the switch-to-display datapath. Samples eight slide switches, synchronises and debounces them, then priority-encodes the highest set switch into a registered 3-bit index. `encoded` feeds the 7-segment digit driver's `encoded` input directly; `valid` drives a status LED; `changed` is a one-cycle pulse for any downstream logger or counter.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 16: consecutive identical synchronised samples required to accept a new switch vector. Legal range is 2..65535; the counter width is `$clog2(DEBOUNCE_CYCLES+1)`.

Ports:
- `clk` in 1: single clock; all state is on the rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `en` in 1: encode enable, synchronous to `clk`; low forces the outputs to the "no input" code.
- `sw` in 8: raw switch levels, asynchronous to `clk`.
- `encoded` out 3: index of the highest set bit of the accepted switch vector.
- `valid` out 1: high when `en` is high and at least one accepted switch bit is set.
- `changed` out 1: one-cycle pulse on any update of {`valid`,`encoded`}.

## Operation
- Synchroniser: two flops, `sw` → `s1` → `sw_sync`, both reset to 0.
- Debounce FSM:
  - Registers: `sw_stable[7:0]`, `cand[7:0]`, `cnt`. All reset to 0, state STABLE.
  - STABLE: if `sw_sync != sw_stable`, load `cand <= sw_sync`, set `cnt <= 1`, go to SETTLE.
  - SETTLE, when `sw_sync == sw_stable` (bounced back): go to STABLE, `cnt <= 0`. `sw_stable` is unchanged.
  - SETTLE, else when `sw_sync != cand`: `cand <= sw_sync`, `cnt <= 1`, stay in SETTLE.
  - SETTLE, else when `cnt == DEBOUNCE_CYCLES-1`: `sw_stable <= cand`, `cnt <= 0`, go to STABLE.
  - SETTLE, otherwise: `cnt <= cnt + 1`.
- Encoder: a combinational priority encode of `sw_stable`, registered into the outputs.
  - Bit 7 has the highest priority.
  - If `en`=0 or `sw_stable`=0, the next value is `encoded`=0, `valid`=0.
- `changed`: registered. It is high for exactly one cycle when the new {`valid`,`encoded`} differs from the previous value; otherwise low.
- No back-pressure: outputs are level signals, always current.

## Timing
- Reset values (asynchronous, while `rst`=0):
  - `encoded`=0, `valid`=0, `changed`=0.
  - `s1`, `sw_sync`, `sw_stable`, `cand` are all 0; `cnt`=0; state STABLE.
- Latency, with debounce compiled in: `sw` changes and is held stable; it is first sampled at edge 0.
  - `sw_sync` updates at edge 1.
  - SETTLE is entered at edge 2.
  - `sw_stable` updates at edge `DEBOUNCE_CYCLES+1`.
  - `encoded`/`valid` update and `changed` rises at edge `DEBOUNCE_CYCLES+2`.
  - `changed` falls at the next edge unless another update occurs.
- Any mismatch against `cand` during SETTLE restarts the count.
  - `sw_stable` therefore never takes a vector held for fewer than `DEBOUNCE_CYCLES` consecutive `sw_sync` samples.
- `en` change: takes effect on `encoded`/`valid` at the next edge, with `changed` asserted in that same cycle if the output differs.
- Simultaneous events: if `en` falls on the same edge that `sw_stable` commits, the output goes to 0/invalid.
  - `sw_stable` still commits, so raising `en` later shows the new vector after one edge.
- Reset mid-SETTLE: the pending `cand` is discarded, outputs go to zero, and the FSM resumes from STABLE after release.
  - A held switch vector is re-accepted with full latency after reset release.

## Configuration
- Macro: `SW_PRIO_ENCODER_DEBOUNCE_EN`.
- Defined: the debounce FSM is built as above; the latency from `sw` to output is `DEBOUNCE_CYCLES+2` edges.
- Undefined:
  - The FSM, `cand` and `cnt` are not synthesised, and `DEBOUNCE_CYCLES` is ignored.
  - `sw_stable` is `sw_sync` (combinational alias).
  - The output latency from first sample is 2 edges.
  - Encode, `en` and `changed` behaviour are unchanged.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4 and `SW_PRIO_ENCODER_DEBOUNCE_EN` defined unless stated.
- Reset: hold `rst`=0 with `sw`=8'hFF, `en`=1 → `encoded`=0, `valid`=0, `changed`=0 throughout. After release, `encoded`=7 and `valid`=1 at edge 6 after release, with a one-cycle `changed` pulse.
- Priority: `sw`=8'b0010_0110 steady → `encoded`=5, `valid`=1 at edge 6. Then `sw`=8'b0000_0001 → `encoded`=0, `valid`=1, one `changed` pulse. Then `sw`=0 → `encoded`=0, `valid`=0, one `changed` pulse.
- Bounce: from `sw`=0, toggle `sw` 8'h08/8'h00 every 2 cycles for 20 cycles, then hold 8'h08.
  - During the toggling, `valid` stays 0 and `changed` stays 0.
  - `encoded`=3 at edge 6 after the final hold's first sample.
- Enable: with `sw_stable`=8'h40, drop `en` → next edge `valid`=0, `encoded`=0, `changed`=1. Raise `en` → next edge `encoded`=6, `valid`=1, `changed`=1.
- Reset mid-SETTLE: `sw` changes from 8'h01 to 8'h80, and `rst` is pulsed low at edge 3 → outputs 0 immediately. After release, `encoded`=7 appears 6 edges later.
- Macro undefined: `sw`=8'h10 → `encoded`=4, `valid`=1 at edge 2. A one-cycle glitch on `sw` propagates to the output.
